// File: rtl/axi_tlb_lookup_mc.sv
// Multi-channel L1 TLB range lookup with registered results, per-channel saturating miss counters
// and optional first-miss address capture (enabled by defining AXI_TLB_MISS_CAPTURE_EN).
module axi_tlb_lookup_mc #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned NumEntries   = 4,
  parameter int unsigned InpAddrWidth = 32,
  parameter int unsigned OupAddrWidth = 32,
  parameter int unsigned PageWidth    = 12,
  parameter logic [NumChannels-1:0] WrChannels = '0,
  parameter int unsigned CntWidth     = 16,
  localparam int unsigned InpPageWidth = InpAddrWidth - PageWidth,
  localparam int unsigned OupPageWidth = OupAddrWidth - PageWidth
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic [NumChannels-1:0][InpAddrWidth-1:0]    req_addr_i,
  input  logic [NumChannels-1:0]                      req_valid_i,
  output logic [NumChannels-1:0]                      req_ready_o,
  output logic [NumChannels-1:0]                      res_hit_o,
  output logic [NumChannels-1:0][OupAddrWidth-1:0]    res_addr_o,
  output logic [NumChannels-1:0]                      res_valid_o,
  input  logic [NumChannels-1:0]                      res_ready_i,
  input  logic [NumEntries-1:0]                       entry_valid_i,
  input  logic [NumEntries-1:0][InpPageWidth-1:0]     entry_first_i,
  input  logic [NumEntries-1:0][InpPageWidth-1:0]     entry_last_i,
  input  logic [NumEntries-1:0][OupPageWidth-1:0]     entry_base_i,
  input  logic [NumEntries-1:0]                       entry_ro_i,
  input  logic                                        cnt_clr_i,
  output logic [NumChannels-1:0][CntWidth-1:0]        miss_cnt_o,
  output logic [NumChannels-1:0][InpAddrWidth-1:0]    miss_addr_o,
  output logic [NumChannels-1:0]                      miss_addr_valid_o
);

  localparam int unsigned DiffWidth = (InpPageWidth > OupPageWidth) ? InpPageWidth : OupPageWidth;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    logic [InpPageWidth-1:0] page;
    logic                    match_found;
    logic                    match_ro;
    logic [OupPageWidth-1:0] match_page;
    logic                    lookup_hit;
    logic [OupAddrWidth-1:0] lookup_addr;
    logic                    accept;
    logic                    res_valid_reg;
    logic                    res_hit_reg;
    logic [OupAddrWidth-1:0] res_addr_reg;
    logic [CntWidth-1:0]     miss_cnt_reg;

    assign page = req_addr_i[gi][InpAddrWidth-1:PageWidth];

    // Walk entries from the top down so the lowest-index match is the one left standing.
    always_comb begin
      match_found = 1'b0;
      match_ro    = 1'b0;
      match_page  = '0;
      for (int e = int'(NumEntries) - 1; e >= 0; e--) begin
        if (entry_valid_i[e] && (page >= entry_first_i[e]) && (page <= entry_last_i[e])) begin
          match_found = 1'b1;
          match_ro    = entry_ro_i[e];
          match_page  = entry_base_i[e]
                      + OupPageWidth'(DiffWidth'(page) - DiffWidth'(entry_first_i[e]));
        end
      end
    end

    // A read-only winner on a write channel is a miss; no fall-through to later entries.
    assign lookup_hit  = match_found && !(WrChannels[gi] && match_ro);
    assign lookup_addr = lookup_hit ? {match_page, req_addr_i[gi][PageWidth-1:0]} : '0;

    assign req_ready_o[gi] = !res_valid_reg || res_ready_i[gi];
    assign accept          = req_valid_i[gi] && req_ready_o[gi];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        res_valid_reg <= 1'b0;
        res_hit_reg   <= 1'b0;
        res_addr_reg  <= '0;
      end else if (accept) begin
        res_valid_reg <= 1'b1;
        res_hit_reg   <= lookup_hit;
        res_addr_reg  <= lookup_addr;
      end else if (res_ready_i[gi]) begin
        res_valid_reg <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
        miss_cnt_reg <= '0;
      end else if (accept && !lookup_hit && (miss_cnt_reg != '1)) begin
        miss_cnt_reg <= miss_cnt_reg + CntWidth'(1);
      end
    end

`ifdef AXI_TLB_MISS_CAPTURE_EN
    logic [InpAddrWidth-1:0] miss_addr_reg;
    logic                    miss_addr_valid_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i || cnt_clr_i) begin
        miss_addr_reg       <= '0;
        miss_addr_valid_reg <= 1'b0;
      end else if (accept && !lookup_hit && !miss_addr_valid_reg) begin
        miss_addr_reg       <= req_addr_i[gi];
        miss_addr_valid_reg <= 1'b1;
      end
    end

    assign miss_addr_o[gi]       = miss_addr_reg;
    assign miss_addr_valid_o[gi] = miss_addr_valid_reg;
`else
    assign miss_addr_o[gi]       = '0;
    assign miss_addr_valid_o[gi] = 1'b0;
`endif

    assign res_valid_o[gi] = res_valid_reg;
    assign res_hit_o[gi]   = res_hit_reg;
    assign res_addr_o[gi]  = res_addr_reg;
    assign miss_cnt_o[gi]  = miss_cnt_reg;
  end

endmodule
